// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg - shared definitions for the parametrised accumulator CPU.
//   * opcode encodings (OP_ADD .. OP_ROUND / OP_JMPZ)
//   * control FSM state enum
//   * instruction-register field positions as functions of DW
// Optional feature macro: ACC_CPU_JMPZ_EN (opcode 7 becomes JMPZ instead of ROUND).
`timescale 1ns/1ps
package acc_cpu_pkg;

  typedef logic [2:0] opc_t;

  localparam opc_t OP_ADD    = 3'd0;
  localparam opc_t OP_ASHL   = 3'd1;
  localparam opc_t OP_XNOR   = 3'd2;
  localparam opc_t OP_DIV2   = 3'd3;
  localparam opc_t OP_LOAD   = 3'd4;
  localparam opc_t OP_STORE  = 3'd5;
  localparam opc_t OP_COMP2S = 3'd6;
  // Opcode 7 is shared: ROUND in the default build, JMPZ with ACC_CPU_JMPZ_EN.
  localparam opc_t OP_ROUND  = 3'd7;
  localparam opc_t OP_JMPZ   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_R,
    ST_DECODE,
    ST_INDIRECT,
    ST_EXEC_M,
    ST_EXEC_A
  } state_t;

  // IR layout: {I, OPC[2:0], ADDR}; ADDR occupies the low AW bits (DW-4 >= AW).
  function automatic int ir_i_pos(input int dw);
    return dw - 1;
  endfunction

  function automatic int ir_opc_hi(input int dw);
    return dw - 2;
  endfunction

  function automatic int ir_opc_lo(input int dw);
    return dw - 4;
  endfunction

endpackage

// File: rtl/acc_cpu_param_if.sv
// acc_cpu_param_if - memory bus between the CPU (master) and the memory (slave).
//   addr  : word address (CPU AR register)
//   rd/wr : read / write request, held until ack; never both high
//   wdata : write data (accumulator), valid while wr
//   rdata : read data, sampled by the CPU in the cycle with rd & ack
//   ack   : completes the pending request in the current cycle
// Optional feature macro used by the CPU: ACC_CPU_JMPZ_EN (no effect on this bus).
`timescale 1ns/1ps
interface acc_cpu_param_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (
    output addr, rd, wr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  addr, rd, wr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu - combinational ALU of the accumulator CPU.
//   opc_i       : opcode (IR[DW-2:DW-4])
//   ac_i        : current accumulator
//   m_i         : memory operand (DR)
//   result_o    : new accumulator value
//   carry_out_o : new carry value
//   carry_we_o  : 1 when the opcode updates carry
// Optional feature macro: ACC_CPU_JMPZ_EN - opcode 7 is a jump handled by the
// control FSM, so the ALU treats it as a no-op; otherwise opcode 7 is ROUND.
`timescale 1ns/1ps
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  opc_t          opc_i,
  input  logic [DW-1:0] ac_i,
  input  logic [DW-1:0] m_i,
  output logic [DW-1:0] result_o,
  output logic          carry_out_o,
  output logic          carry_we_o
);

  logic [DW:0] sum;
  assign sum = {1'b0, ac_i} + {1'b0, m_i};

`ifndef ACC_CPU_JMPZ_EN
  // ROUND adds one in DW+1 bits so 0xFF..F rounds up to the top bit instead of wrapping.
  logic [DW:0] rnd;
  assign rnd = {1'b0, m_i} + {{DW{1'b0}}, 1'b1};
`endif

  always_comb begin
    result_o    = ac_i;
    carry_out_o = 1'b0;
    carry_we_o  = 1'b0;
    case (opc_i)
      OP_ADD: begin
        result_o    = sum[DW-1:0];
        carry_out_o = sum[DW];
        carry_we_o  = 1'b1;
      end
      OP_ASHL: begin
        result_o    = {m_i[DW-2:0], 1'b0};
        carry_out_o = m_i[DW-1];
        carry_we_o  = 1'b1;
      end
      OP_XNOR: begin
        result_o = ~(ac_i ^ m_i);
      end
      OP_DIV2: begin
        result_o    = {m_i[DW-1], m_i[DW-1:1]};
        carry_out_o = m_i[0];
        carry_we_o  = 1'b1;
      end
      OP_LOAD: begin
        result_o = m_i;
      end
      OP_COMP2S: begin
        result_o    = -m_i;
        carry_out_o = |m_i;
        carry_we_o  = 1'b1;
      end
      default: begin
`ifndef ACC_CPU_JMPZ_EN
        result_o    = rnd[DW:1];
        carry_out_o = 1'b0;
        carry_we_o  = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/acc_cpu_param.sv
// acc_cpu_param - parametrised multi-cycle accumulator CPU, one instruction in flight.
//   clk    : clock, rising edge
//   clr    : asynchronous active-high reset
//   run    : 1 = keep fetching, 0 = stop to IDLE after the current instruction
//   mem    : memory bus (acc_cpu_param_if.master): addr=AR, rd/wr requests held until ack
//   ac_out : accumulator
//   carry  : carry/borrow flag
//   pc_out : program counter
//   idle   : 1 while in IDLE
// Parameters: DW data/instruction width (IR = {I, OPC, ADDR}), AW address width; DW-4 >= AW.
// Optional feature macro: ACC_CPU_JMPZ_EN - opcode 7 becomes JMPZ (PC <= effective
// address when AC == 0, no memory access); default build implements ROUND.
`timescale 1ns/1ps
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            run,
  acc_cpu_param_if.master mem,
  output logic [DW-1:0]   ac_out,
  output logic            carry,
  output logic [AW-1:0]   pc_out,
  output logic            idle
);

  localparam int I_POS  = ir_i_pos(DW);
  localparam int OPC_HI = ir_opc_hi(DW);
  localparam int OPC_LO = ir_opc_lo(DW);
  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] ar_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] dr_q;
  logic [DW-1:0] ac_q;
  logic          carry_q;
  logic          rd_q;
  logic          wr_q;

  opc_t          opc;
  logic          is_jmpz;
  logic          exec_rd_d;
  logic          exec_wr_d;
  logic          req_done_d;
  state_t        after_state_d;
  logic [AW-1:0] pc_inc_d;

  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_carry_we;

  assign opc = ir_q[OPC_HI:OPC_LO];

`ifdef ACC_CPU_JMPZ_EN
  assign is_jmpz = (opc == OP_JMPZ);
`else
  assign is_jmpz = 1'b0;
`endif

  // Memory phase of EXEC_M: STORE writes, JMPZ touches no memory, all else reads DR.
  assign exec_wr_d = (opc == OP_STORE);
  assign exec_rd_d = (opc != OP_STORE) && !is_jmpz;

  // An ack only counts while a request is actually outstanding.
  assign req_done_d    = mem.ack && (rd_q || wr_q);
  assign after_state_d = run ? ST_FETCH_A : ST_IDLE;
  assign pc_inc_d      = pc_q + PC_ONE;

  acc_cpu_alu #(.DW(DW)) u_alu (
    .opc_i       (opc),
    .ac_i        (ac_q),
    .m_i         (dr_q),
    .result_o    (alu_result),
    .carry_out_o (alu_carry),
    .carry_we_o  (alu_carry_we)
  );

  // Request strobes are registered and asserted on entry to the requesting state,
  // so addr/rd/wr come straight from flops and stay put through wait states.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      dr_q    <= '0;
      ac_q    <= '0;
      carry_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_FETCH_A;
        end
        ST_FETCH_A: begin
          ar_q    <= pc_q;
          rd_q    <= 1'b1;
          state_q <= ST_FETCH_R;
        end
        ST_FETCH_R: begin
          if (req_done_d) begin
            ir_q    <= mem.rdata;
            pc_q    <= pc_inc_d;
            rd_q    <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          ar_q <= ir_q[AW-1:0];
          if (ir_q[I_POS]) begin
            rd_q    <= 1'b1;
            state_q <= ST_INDIRECT;
          end else begin
            rd_q    <= exec_rd_d;
            wr_q    <= exec_wr_d;
            state_q <= ST_EXEC_M;
          end
        end
        ST_INDIRECT: begin
          if (req_done_d) begin
            ar_q    <= mem.rdata[AW-1:0];
            rd_q    <= exec_rd_d;
            wr_q    <= exec_wr_d;
            state_q <= ST_EXEC_M;
          end
        end
        ST_EXEC_M: begin
          if (is_jmpz) begin
            if (ac_q == '0) pc_q <= ar_q;
            state_q <= after_state_d;
          end else if (req_done_d) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (wr_q) begin
              state_q <= after_state_d;
            end else begin
              dr_q    <= mem.rdata;
              state_q <= ST_EXEC_A;
            end
          end
        end
        ST_EXEC_A: begin
          ac_q <= alu_result;
          if (alu_carry_we) carry_q <= alu_carry;
          state_q <= after_state_d;
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem.addr  = ar_q;
  assign mem.rd    = rd_q;
  assign mem.wr    = wr_q;
  assign mem.wdata = ac_q;

  assign ac_out = ac_q;
  assign carry  = carry_q;
  assign pc_out = pc_q;
  assign idle   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_acc_cpu_param.sv
// tb_acc_cpu_param - directed self-checking bench for acc_cpu_param (DW=8, AW=4).
// Memory model with programmable ack delay; one task per scenario.
// Optional feature macro: ACC_CPU_JMPZ_EN selects the JMPZ scenario instead of ROUND.
`timescale 1ns/1ps
module tb_acc_cpu_param;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          run = 1'b0;
  logic [DW-1:0] ac_out;
  logic          carry;
  logic [AW-1:0] pc_out;
  logic          idle;

  int checks = 0;
  int passes = 0;

  acc_cpu_param_if #(.DW(DW), .AW(AW)) bus ();

  acc_cpu_param #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .mem    (bus),
    .ac_out (ac_out),
    .carry  (carry),
    .pc_out (pc_out),
    .idle   (idle)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [16];
  logic [DW-1:0] img [16];
  logic          load_req  = 1'b0;
  logic          ack_force = 1'b0;
  int            ack_delay = 0;
  int            wait_cnt  = 0;
  logic          req;

  assign req       = bus.rd | bus.wr;
  assign bus.ack   = (req && (wait_cnt == ack_delay)) || ack_force;
  assign bus.rdata = mem[bus.addr];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
    end else if (bus.wr && bus.ack) begin
      mem[bus.addr] <= bus.wdata;
    end
    if (req && !bus.ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  logic unstable_seen = 1'b0;
  logic both_seen     = 1'b0;

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
  endtask

  // Reset the CPU and copy img into memory; returns at posedge+1.
  task automatic apply_reset();
    run       = 1'b0;
    ack_force = 1'b0;
    clr       = 1'b1;
    load_req  = 1'b1;
    @(posedge clk); #1;
    load_req  = 1'b0;
    clr       = 1'b0;
  endtask

  // Run exactly one instruction from IDLE; cyc = cycles until idle again.
  task automatic exec_one(output int cyc, output int wr_cycles);
    logic prev_rd, prev_wr, prev_ack;
    logic [AW-1:0] prev_addr;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    cyc = 0; wr_cycles = 0;
    run = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) run = 1'b0;
      if (bus.wr) wr_cycles++;
      if (bus.rd && bus.wr) both_seen = 1'b1;
      if ((prev_rd || prev_wr) && !prev_ack &&
          (bus.rd !== prev_rd || bus.wr !== prev_wr || bus.addr !== prev_addr))
        unstable_seen = 1'b1;
      prev_rd = bus.rd; prev_wr = bus.wr; prev_ack = bus.ack; prev_addr = bus.addr;
    end while (!idle && cyc < 100);
    if (!idle) begin
      checks++;
      $display("FAIL exec_timeout: idle=%0b after %0d cycles, required idle=1", idle, cyc);
    end
  endtask

  task automatic test_reset();
    clear_img();
    apply_reset();
    checks++; if (ac_out !== 8'h00) $display("FAIL rst_ac: got %h want 00", ac_out); else passes++;
    checks++; if (carry !== 1'b0) $display("FAIL rst_carry: got %b want 0", carry); else passes++;
    checks++; if (pc_out !== 4'h0) $display("FAIL rst_pc: got %h want 0", pc_out); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else passes++;
    checks++; if (bus.rd !== 1'b0 || bus.wr !== 1'b0)
      $display("FAIL rst_req: got rd=%b wr=%b want 0/0", bus.rd, bus.wr); else passes++;
    checks++; if (bus.addr !== 4'h0) $display("FAIL rst_addr: got %h want 0", bus.addr); else passes++;
    $display("reset: ac=%h carry=%b pc=%h idle=%b", ac_out, carry, pc_out, idle);
  endtask

  task automatic test_load_add();
    int done_cyc;
    logic exec_rd;
    logic [AW-1:0] exec_addr;
    clear_img();
    img[0] = 8'h45; img[1] = 8'h06; img[5] = 8'hF0; img[6] = 8'h20;
    apply_reset();
    done_cyc = 0; exec_rd = 1'b0; exec_addr = '0;
    run = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_cyc == 0 && ac_out == 8'hF0) done_cyc = c;
      if (c == 9) begin
        exec_rd = bus.rd; exec_addr = bus.addr;
        run = 1'b0;   // drop run while ADD is in EXEC_M
      end
      if (c > 1 && idle) break;
    end
    run = 1'b0;
    checks++; if (done_cyc !== 6) $display("FAIL load_latency: got %0d want 6", done_cyc); else passes++;
    checks++; if (exec_rd !== 1'b1 || exec_addr !== 4'h6)
      $display("FAIL add_exec_m: got rd=%b addr=%h want 1/6", exec_rd, exec_addr); else passes++;
    checks++; if (ac_out !== 8'h10) $display("FAIL add_ac: got %h want 10", ac_out); else passes++;
    checks++; if (carry !== 1'b1) $display("FAIL add_carry: got %b want 1", carry); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL run_stop_idle: got %b want 1", idle); else passes++;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pc_out !== 4'h2 || idle !== 1'b1)
      $display("FAIL pc_frozen: got pc=%h idle=%b want 2/1", pc_out, idle); else passes++;
    $display("load_add: load_cyc=%0d ac=%h carry=%b pc=%h", done_cyc, ac_out, carry, pc_out);
  endtask

  task automatic test_store_indirect();
    int cyc, wrc;
    clear_img();
    img[0] = 8'h4B; img[11] = 8'h10; img[1] = 8'hD8; img[8] = 8'h0C;
    apply_reset();
    exec_one(cyc, wrc);
    exec_one(cyc, wrc);
    checks++; if (cyc !== 6) $display("FAIL store_ind_latency: got %0d want 6", cyc); else passes++;
    checks++; if (wrc !== 1) $display("FAIL store_wr_pulse: got %0d cycles want 1", wrc); else passes++;
    checks++; if (mem[12] !== 8'h10) $display("FAIL store_mem12: got %h want 10", mem[12]); else passes++;
    checks++; if (ac_out !== 8'h10 || pc_out !== 4'h2)
      $display("FAIL store_state: got ac=%h pc=%h want 10/2", ac_out, pc_out); else passes++;
    $display("store_indirect: cyc=%0d wr_cycles=%0d mem12=%h", cyc, wrc, mem[12]);
  endtask

  task automatic test_wait_states();
    int cyc, wrc;
    clear_img();
    img[0] = 8'h45; img[5] = 8'hF0;
    apply_reset();
    ack_delay = 3; unstable_seen = 1'b0; both_seen = 1'b0;
    exec_one(cyc, wrc);
    ack_delay = 0;
    checks++; if (cyc !== 12) $display("FAIL wait_latency: got %0d want 12", cyc); else passes++;
    checks++; if (ac_out !== 8'hF0) $display("FAIL wait_ac: got %h want F0", ac_out); else passes++;
    checks++; if (unstable_seen !== 1'b0) $display("FAIL wait_stable: got unstable=%b want 0", unstable_seen); else passes++;
    checks++; if (both_seen !== 1'b0) $display("FAIL rd_wr_excl: got both=%b want 0", both_seen); else passes++;
    $display("wait_states: cyc=%0d ac=%h", cyc, ac_out);
  endtask

  task automatic test_alu();
    int cyc, wrc;
    clear_img();
    img[0] = 8'h19; img[1] = 8'h39; img[2] = 8'h29; img[3] = 8'h79;
    img[4] = 8'h69; img[5] = 8'h6A; img[9] = 8'h81; img[10] = 8'h00;
    apply_reset();
    exec_one(cyc, wrc);
    checks++; if (ac_out !== 8'h02 || carry !== 1'b1)
      $display("FAIL alu_ashl: got %h/%b want 02/1", ac_out, carry); else passes++;
    exec_one(cyc, wrc);
    checks++; if (ac_out !== 8'hC0 || carry !== 1'b1)
      $display("FAIL alu_div2: got %h/%b want C0/1", ac_out, carry); else passes++;
    exec_one(cyc, wrc);
    checks++; if (ac_out !== 8'hBE || carry !== 1'b1)
      $display("FAIL alu_xnor: got %h/%b want BE/1", ac_out, carry); else passes++;
    exec_one(cyc, wrc);
`ifdef ACC_CPU_JMPZ_EN
    checks++; if (ac_out !== 8'hBE || pc_out !== 4'h4)
      $display("FAIL jmpz_nonzero: got ac=%h pc=%h want BE/4", ac_out, pc_out); else passes++;
`else
    checks++; if (ac_out !== 8'h41 || carry !== 1'b0)
      $display("FAIL alu_round: got %h/%b want 41/0", ac_out, carry); else passes++;
`endif
    exec_one(cyc, wrc);
    checks++; if (ac_out !== 8'h7F || carry !== 1'b1)
      $display("FAIL alu_comp2s: got %h/%b want 7F/1", ac_out, carry); else passes++;
    exec_one(cyc, wrc);
    checks++; if (ac_out !== 8'h00 || carry !== 1'b0)
      $display("FAIL alu_comp2s_zero: got %h/%b want 00/0", ac_out, carry); else passes++;
    $display("alu: final ac=%h carry=%b pc=%h", ac_out, carry, pc_out);
  endtask

`ifdef ACC_CPU_JMPZ_EN
  task automatic test_jmpz();
    int cyc, wrc;
    clear_img();
    img[0] = 8'h4A; img[1] = 8'h73; img[3] = 8'h49; img[4] = 8'h70;
    img[9] = 8'h81; img[10] = 8'h00;
    apply_reset();
    exec_one(cyc, wrc);
    exec_one(cyc, wrc);
    checks++; if (pc_out !== 4'h3) $display("FAIL jmpz_taken: got pc=%h want 3", pc_out); else passes++;
    exec_one(cyc, wrc);
    exec_one(cyc, wrc);
    checks++; if (pc_out !== 4'h5 || ac_out !== 8'h81)
      $display("FAIL jmpz_not_taken: got pc=%h ac=%h want 5/81", pc_out, ac_out); else passes++;
    $display("jmpz: pc=%h ac=%h", pc_out, ac_out);
  endtask
`endif

  task automatic test_ack_ignored();
    clear_img();
    apply_reset();
    ack_force = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack_force = 1'b0;
    checks++; if (pc_out !== 4'h0 || idle !== 1'b1 || bus.rd !== 1'b0 || ac_out !== 8'h00)
      $display("FAIL stray_ack: got pc=%h idle=%b rd=%b ac=%h want 0/1/0/00",
               pc_out, idle, bus.rd, ac_out); else passes++;
    $display("ack_ignored: pc=%h idle=%b", pc_out, idle);
  endtask

  task automatic test_clr_mid();
    int cyc, wrc, n;
    clear_img();
    img[0] = 8'h45; img[5] = 8'hF0; img[1] = 8'h05;
    apply_reset();
    exec_one(cyc, wrc);
    ack_delay = 3;
    run = 1'b1;
    n = 0;
    while (bus.rd !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (bus.rd !== 1'b1 || ac_out !== 8'hF0 || pc_out !== 4'h1)
      $display("FAIL clr_setup: got rd=%b ac=%h pc=%h want 1/F0/1", bus.rd, ac_out, pc_out); else passes++;
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    checks++; if (bus.rd !== 1'b0 || bus.wr !== 1'b0)
      $display("FAIL clr_req: got rd=%b wr=%b want 0/0", bus.rd, bus.wr); else passes++;
    checks++; if (idle !== 1'b1) $display("FAIL clr_idle: got %b want 1", idle); else passes++;
    checks++; if (ac_out !== 8'h00 || pc_out !== 4'h0 || carry !== 1'b0 || bus.addr !== 4'h0)
      $display("FAIL clr_zero: got ac=%h pc=%h c=%b addr=%h want all 0",
               ac_out, pc_out, carry, bus.addr); else passes++;
    run = 1'b0;
    ack_delay = 0;
    @(posedge clk); #1;
    clr = 1'b0;
    $display("clr_mid: rd=%b idle=%b ac=%h", bus.rd, idle, ac_out);
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_store_indirect();
    test_wait_states();
    test_alu();
`ifdef ACC_CPU_JMPZ_EN
    test_jmpz();
`endif
    test_ack_ignored();
    test_clr_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
